zvs_duty_sequencer: RTL and testbench

- Drive-level controller that sequences the PWM duty command fed to the angular-encoder speed loop.
- Soft-starts the duty toward a target and tracks target changes at a fixed update-tick rate.
- Watches measured encoder rate for stall, then auto-restarts after a cool-down.
- Sits between the host duty setpoint and the encoder/PWM datapath; all decisions are made on a divided update tick.

---
 rtl/zvs_duty_sequencer_if.sv | 36 +++
 rtl/zvs_duty_sequencer.sv | 166 ++++++++++++++++
 tb/tb_zvs_duty_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/zvs_duty_sequencer_if.sv
// zvs_duty_sequencer_if -- host/datapath bundle for the ZVS duty sequencer.
// Rev 1.0. Optional Fault signal present when SEQ_FAULT_LATCH_EN is defined.
`default_nettype none

interface zvs_duty_sequencer_if;
    logic       enable;
    logic [7:0] duty_target;
    logic [7:0] rate_in;
    logic       rate_valid;
    logic [7:0] duty_cmd;
    logic       tick;
    logic       run;
    logic       stall;
    logic [2:0] state;
`ifdef SEQ_FAULT_LATCH_EN
    logic       fault;
`endif

    modport master (
        output enable, duty_target, rate_in, rate_valid,
        input  duty_cmd, tick, run, stall, state
`ifdef SEQ_FAULT_LATCH_EN
        , input fault
`endif
    );

    modport slave (
        input  enable, duty_target, rate_in, rate_valid,
        output duty_cmd, tick, run, stall, state
`ifdef SEQ_FAULT_LATCH_EN
        , output fault
`endif
    );
endinterface

`default_nettype wire

// File: rtl/zvs_duty_sequencer.sv
// zvs_duty_sequencer -- soft-start duty ramp with stall detect and auto-restart on a divided tick.
// Rev 1.0. SEQ_FAULT_LATCH_EN: stall latches into FAULT instead of auto-restarting.
`default_nettype none

module zvs_duty_sequencer #(
    parameter int TICK_DIV      = 1707,
    parameter int RAMP_STEP     = 1,
    parameter int RATE_MIN      = 10,
    parameter int STALL_TICKS   = 8,
    parameter int RESTART_TICKS = 30
) (
    input  wire logic             clk,
    input  wire logic             rst,
    zvs_duty_sequencer_if.slave   bus
);

    localparam int         c_tick_w   = $clog2(TICK_DIV);
    localparam logic [7:0] c_step     = 8'(RAMP_STEP);
    localparam logic [7:0] c_rate_min = 8'(RATE_MIN);

    localparam logic [2:0] c_st_idle         = 3'd0;
    localparam logic [2:0] c_st_ramp         = 3'd1;
    localparam logic [2:0] c_st_run          = 3'd2;
    localparam logic [2:0] c_st_stall        = 3'd3;
    localparam logic [2:0] c_st_restart_wait = 3'd4;
`ifdef SEQ_FAULT_LATCH_EN
    localparam logic [2:0] c_st_fault        = 3'd5;
`endif

    logic [c_tick_w-1:0] r_tick_cnt;
    logic [7:0]          r_rate_q;
    logic                r_seen;
    logic [2:0]          r_state;
    logic [7:0]          r_duty;
    logic [15:0]         r_stall_cnt;
    logic [15:0]         r_restart_cnt;

    logic                w_tick;
    logic                w_seen;
    logic [7:0]          w_rate;
    logic [8:0]          w_sum;
    logic [7:0]          w_next_duty;
    logic                w_stall_cond;

    assign w_tick = (r_tick_cnt == c_tick_w'(TICK_DIV - 1));

    // A rate strobe landing on the tick cycle itself still counts for that tick.
    assign w_seen = r_seen | bus.rate_valid;
    assign w_rate = bus.rate_valid ? bus.rate_in : r_rate_q;

    // 9-bit sum so a step near full scale saturates at the target instead of wrapping.
    assign w_sum = {1'b0, r_duty} + {1'b0, c_step};

    always_comb begin
        w_next_duty = bus.duty_target;
        if (bus.duty_target > r_duty && w_sum < {1'b0, bus.duty_target}) begin
            w_next_duty = w_sum[7:0];
        end
    end

    assign w_stall_cond = (r_duty > c_rate_min) && (!w_seen || (w_rate <= c_rate_min));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_rate_q   <= 8'd0;
            r_seen     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (bus.rate_valid) begin
                r_rate_q <= bus.rate_in;
            end
            if (w_tick) begin
                r_seen <= 1'b0;
            end else if (bus.rate_valid) begin
                r_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            r_state       <= c_st_idle;
            r_duty        <= 8'd0;
            r_stall_cnt   <= 16'd0;
            r_restart_cnt <= 16'd0;
        end else if (w_tick) begin
            case (r_state)
                c_st_idle: begin
                    r_duty <= 8'd0;
                    if (bus.duty_target != 8'd0) begin
                        r_state <= c_st_ramp;
                    end
                end
                c_st_ramp: begin
                    if (bus.duty_target == 8'd0) begin
                        r_duty  <= 8'd0;
                        r_state <= c_st_idle;
                    end else begin
                        r_duty <= w_next_duty;
                        if (w_next_duty == bus.duty_target) begin
                            r_state     <= c_st_run;
                            r_stall_cnt <= 16'd0;
                        end
                    end
                end
                c_st_run: begin
                    if (bus.duty_target == 8'd0) begin
                        r_duty      <= 8'd0;
                        r_state     <= c_st_idle;
                        r_stall_cnt <= 16'd0;
                    end else if (w_stall_cond && r_stall_cnt == 16'(STALL_TICKS - 1)) begin
                        r_duty      <= 8'd0;
                        r_state     <= c_st_stall;
                        r_stall_cnt <= 16'd0;
                    end else begin
                        r_duty      <= w_next_duty;
                        r_stall_cnt <= w_stall_cond ? r_stall_cnt + 16'd1 : 16'd0;
                    end
                end
                c_st_stall: begin
                    r_duty        <= 8'd0;
                    r_restart_cnt <= 16'd0;
`ifdef SEQ_FAULT_LATCH_EN
                    r_state       <= c_st_fault;
`else
                    r_state       <= c_st_restart_wait;
`endif
                end
                c_st_restart_wait: begin
                    r_duty <= 8'd0;
                    if (r_restart_cnt == 16'(RESTART_TICKS - 1)) begin
                        r_restart_cnt <= 16'd0;
                        r_state       <= c_st_idle;
                    end else begin
                        r_restart_cnt <= r_restart_cnt + 16'd1;
                    end
                end
`ifdef SEQ_FAULT_LATCH_EN
                c_st_fault: begin
                    r_duty <= 8'd0;
                end
`endif
                default: begin
                    r_duty  <= 8'd0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.duty_cmd = r_duty;
    assign bus.tick     = w_tick;
    assign bus.state    = r_state;
    assign bus.run      = (r_state == c_st_ramp) || (r_state == c_st_run);
`ifdef SEQ_FAULT_LATCH_EN
    assign bus.stall    = (r_state == c_st_stall) || (r_state == c_st_restart_wait) ||
                          (r_state == c_st_fault);
    assign bus.fault    = (r_state == c_st_fault);
`else
    assign bus.stall    = (r_state == c_st_stall) || (r_state == c_st_restart_wait);
`endif

endmodule

`default_nettype wire

// File: tb/tb_zvs_duty_sequencer.sv
// tb_zvs_duty_sequencer -- directed self-checking bench with small tick/ramp parameters.
// Rev 1.0. Fault-latch steps run only when SEQ_FAULT_LATCH_EN is defined.
`default_nettype none

module tb_zvs_duty_sequencer;

    localparam int TICK_DIV      = 4;
    localparam int RAMP_STEP     = 16;
    localparam int RATE_MIN      = 10;
    localparam int STALL_TICKS   = 3;
    localparam int RESTART_TICKS = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    zvs_duty_sequencer_if bus ();

    zvs_duty_sequencer #(
        .TICK_DIV      (TICK_DIV),
        .RAMP_STEP     (RAMP_STEP),
        .RATE_MIN      (RATE_MIN),
        .STALL_TICKS   (STALL_TICKS),
        .RESTART_TICKS (RESTART_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance through the next tick edge, optionally strobing a rate sample
    // either on the cycle right after the previous tick (early) or on the tick cycle.
    task automatic tick_step(input bit rv, input bit early, input logic [7:0] rate,
                             input int exp_wait);
        int n = 0;
        if (rv && early) begin
            bus.rate_valid = 1'b1;
            bus.rate_in    = rate;
            cyc();
            bus.rate_valid = 1'b0;
            n++;
        end
        while (bus.tick !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
        if (n >= 16) chk("tick_timeout", 16'(bus.tick), 16'd1);
        if (exp_wait >= 0) chk("tick_period", 16'(n), 16'(exp_wait));
        if (rv && !early) begin
            bus.rate_valid = 1'b1;
            bus.rate_in    = rate;
        end
        cyc();
        bus.rate_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic [7:0] duty,
                              input logic run_e, input logic stall_e);
        chk({tag, "_state"}, 16'(bus.state), 16'(st));
        chk({tag, "_duty"},  16'(bus.duty_cmd), 16'(duty));
        chk({tag, "_run"},   16'(bus.run), 16'(run_e));
        chk({tag, "_stall"}, 16'(bus.stall), 16'(stall_e));
    endtask

    // From IDLE with target 64: one tick to enter RAMP, then 16/32/48/64.
    task automatic ramp64(input string tag, input int first_wait);
        bus.duty_target = 8'd64;
        tick_step(1'b1, 1'b0, 8'd50, first_wait);
        expect_out({tag, "_enter"}, 3'd1, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick_step(1'b1, 1'b0, 8'd50, 3);
            expect_out({tag, "_step"}, (i == 4) ? 3'd2 : 3'd1, 8'(16 * i), 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.enable      = 1'b0;
        bus.duty_target = 8'd0;
        bus.rate_in     = 8'd0;
        bus.rate_valid  = 1'b0;
        repeat (3) cyc();
        expect_out("reset", 3'd0, 8'd0, 1'b0, 1'b0);
        chk("reset_tick", 16'(bus.tick), 16'd0);

        // Soft-start ramp
        rst        = 1'b0;
        bus.enable = 1'b1;
        ramp64("t1", 3);
        chk("t1_tick_low", 16'(bus.tick), 16'd0);

        // Target tracking in RUN
        bus.duty_target = 8'd20;
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t2_down", 3'd2, 8'd20, 1'b1, 1'b0);
        bus.duty_target = 8'd52;
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t2_up1", 3'd2, 8'd36, 1'b1, 1'b0);
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t2_up2", 3'd2, 8'd52, 1'b1, 1'b0);
        bus.duty_target = 8'd0;
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t2_zero", 3'd0, 8'd0, 1'b0, 1'b0);
        ramp64("t2_reramp", 3);

        // Stall from missing rate, restart wait, auto re-ramp
        tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t3_s1", 3'd2, 8'd64, 1'b1, 1'b0);
        tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t3_s2", 3'd2, 8'd64, 1'b1, 1'b0);
        tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t3_stall", 3'd3, 8'd0, 1'b0, 1'b1);
        tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t3_rw1", 3'd4, 8'd0, 1'b0, 1'b1);
        tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t3_rw2", 3'd4, 8'd0, 1'b0, 1'b1);
        tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t3_idle", 3'd0, 8'd0, 1'b0, 1'b0);
        ramp64("t3_reramp", 3);

        // Stall from low rate, then healthy rate never stalls
        tick_step(1'b1, 1'b0, 8'd5, 3);
        expect_out("t4_s1", 3'd2, 8'd64, 1'b1, 1'b0);
        tick_step(1'b1, 1'b0, 8'd5, 3);
        expect_out("t4_s2", 3'd2, 8'd64, 1'b1, 1'b0);
        tick_step(1'b1, 1'b0, 8'd5, 3);
        expect_out("t4_stall", 3'd3, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t4_idle", 3'd0, 8'd0, 1'b0, 1'b0);
        ramp64("t4_reramp", 3);
        for (int i = 0; i < 20; i++) begin
            tick_step(1'b1, i[0], 8'd50, 3);
            expect_out("t4_healthy", 3'd2, 8'd64, 1'b1, 1'b0);
        end

        // Enable drop mid-RAMP on a non-tick cycle, then reset mid-RUN
        bus.duty_target = 8'd0;
        tick_step(1'b1, 1'b0, 8'd50, 3);
        bus.duty_target = 8'd64;
        tick_step(1'b1, 1'b0, 8'd50, 3);
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t5_ramp", 3'd1, 8'd16, 1'b1, 1'b0);
        chk("t5_nontick", 16'(bus.tick), 16'd0);
        bus.enable = 1'b0;
        cyc();
        expect_out("t5_disable", 3'd0, 8'd0, 1'b0, 1'b0);
        bus.enable = 1'b1;
        ramp64("t5_reramp", 2);
        rst = 1'b1;
        cyc();
        expect_out("t5_rst", 3'd0, 8'd0, 1'b0, 1'b0);
        chk("t5_rst_tick", 16'(bus.tick), 16'd0);
        rst = 1'b0;

        // Ramp near full scale must saturate at target, not wrap
        bus.duty_target = 8'd250;
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t6_enter", 3'd1, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick_step(1'b1, 1'b0, 8'd50, 3);
            expect_out("t6_step", 3'd1, 8'(16 * i), 1'b1, 1'b0);
        end
        tick_step(1'b1, 1'b0, 8'd50, 3);
        expect_out("t6_sat", 3'd2, 8'd250, 1'b1, 1'b0);

`ifdef SEQ_FAULT_LATCH_EN
        for (int i = 0; i < 3; i++) tick_step(1'b0, 1'b0, 8'd0, 3);
        expect_out("t7_stall", 3'd3, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick_step(1'b0, 1'b0, 8'd0, 3);
            expect_out("t7_fault", 3'd5, 8'd0, 1'b0, 1'b1);
            chk("t7_fault_flag", 16'(bus.fault), 16'd1);
        end
        bus.enable = 1'b0;
        cyc();
        expect_out("t7_clear", 3'd0, 8'd0, 1'b0, 1'b0);
        chk("t7_fault_clear", 16'(bus.fault), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
